// File: rtl/unpack_input_arbiter_if.sv
// unpack_input_arbiter_if: requester-side and unpacker-side word streams around the input arbiter.
interface unpack_input_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_sop;
    logic [NUM_REQ-1:0]    req_eop;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  arb_valid;
    logic [31:0]           arb_data;
    logic                  arb_sop;
    logic                  arb_eop;
    logic                  arb_ready;

    modport master (
        input  req_valid, req_data, req_sop, req_eop, arb_ready,
        output req_ready, arb_valid, arb_data, arb_sop, arb_eop
    );

    modport slave (
        output req_valid, req_data, req_sop, req_eop, arb_ready,
        input  req_ready, arb_valid, arb_data, arb_sop, arb_eop
    );
endinterface

// File: rtl/unpack_input_arbiter.sv
// unpack_input_arbiter: packet-granular round-robin arbiter feeding one shared 32->7 unpacker (UNPACK_ARB_MAX_PKT_EN adds a MAX_WORDS length limit).
module unpack_input_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
`ifdef UNPACK_ARB_MAX_PKT_EN
    ,
    parameter int MAX_WORDS = 64
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    unpack_input_arbiter_if.master bus,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy,
    output logic [15:0]            drop_cnt,
    output logic                   err_sop
`ifdef UNPACK_ARB_MAX_PKT_EN
    ,
    output logic                   ovf_sticky
`endif
);
    typedef enum logic [1:0] {
        IDLE,
        LOCKED
`ifdef UNPACK_ARB_MAX_PKT_EN
        ,
        DRAIN
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic                err_sop_q, err_sop_d;
    logic [NUM_REQ-1:0]  cand, rdy, drop_mask;
    logic [ID_W-1:0]     win, sel;
    logic                found, sel_v, hs, at_limit;
    logic [4:0]          ndrop;
    logic [16:0]         drop_sum;
`ifdef UNPACK_ARB_MAX_PKT_EN
    logic [15:0]         cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
`endif

    function automatic logic [ID_W-1:0] inc(input logic [ID_W-1:0] id);
        return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
    endfunction

    assign cand  = bus.req_valid & bus.req_sop;
    assign sel   = (state_q == IDLE) ? win : grant_id_q;
    assign sel_v = (state_q == IDLE) ? found : (state_q == LOCKED) ? bus.req_valid[grant_id_q] : 1'b0;
    assign hs    = bus.arb_valid & bus.arb_ready;

`ifdef UNPACK_ARB_MAX_PKT_EN
    // cnt_q counts LOCKED words after the sop word, so the MAX_WORDS-th word sees MAX_WORDS-2
    assign at_limit   = (state_q == LOCKED) && (cnt_q == 16'(MAX_WORDS - 2));
    assign ovf_sticky = ovf_q;
`else
    assign at_limit = 1'b0;
`endif

    assign bus.arb_valid = !rst & sel_v;
    assign bus.arb_data  = rst ? 32'd0 : bus.req_data[{sel, 5'd0} +: 32];
    assign bus.arb_sop   = bus.arb_valid & bus.req_sop[sel];
    assign bus.arb_eop   = bus.arb_valid & (bus.req_eop[sel] | at_limit);
    assign bus.req_ready = rst ? '0 : rdy;

    assign grant_id = grant_id_q;
    assign busy     = state_q != IDLE;
    assign drop_cnt = drop_cnt_q;
    assign err_sop  = err_sop_q;

    // Round-robin pick: first sop candidate at or after rr_ptr, wrapping.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && cand[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // Popcount of words discarded this cycle, added to drop_cnt with saturation.
    always_comb begin
        ndrop = '0;
        for (int k = 0; k < NUM_REQ; k++) ndrop = ndrop + 5'(drop_mask[k]);
    end

    assign drop_sum   = {1'b0, drop_cnt_q} + 17'(ndrop);
    assign drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    // Next state, per-requester ready steering and drop selection.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        err_sop_d  = err_sop_q;
        rdy        = '0;
        drop_mask  = '0;
`ifdef UNPACK_ARB_MAX_PKT_EN
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                drop_mask = bus.req_valid & ~bus.req_sop;
                rdy       = drop_mask;
                if (found) rdy[win] = bus.arb_ready;
                if (hs) begin
                    grant_id_d = win;
`ifdef UNPACK_ARB_MAX_PKT_EN
                    cnt_d = '0;
`endif
                    if (bus.req_eop[win]) rr_ptr_d = inc(win);
                    else state_d = LOCKED;
                end
            end
            LOCKED: begin
                rdy[grant_id_q] = bus.arb_ready;
                if (hs) begin
                    err_sop_d = err_sop_q | bus.req_sop[grant_id_q];
`ifdef UNPACK_ARB_MAX_PKT_EN
                    cnt_d = cnt_q + 16'd1;
`endif
                    if (bus.req_eop[grant_id_q]) begin
                        rr_ptr_d = inc(grant_id_q);
                        state_d  = IDLE;
                    end
`ifdef UNPACK_ARB_MAX_PKT_EN
                    else if (at_limit) begin
                        ovf_d   = 1'b1;
                        state_d = DRAIN;
                    end
`endif
                end
            end
`ifdef UNPACK_ARB_MAX_PKT_EN
            DRAIN: begin
                rdy[grant_id_q]       = 1'b1;
                drop_mask[grant_id_q] = bus.req_valid[grant_id_q];
                if (bus.req_valid[grant_id_q] & bus.req_eop[grant_id_q]) begin
                    rr_ptr_d = inc(grant_id_q);
                    state_d  = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and bookkeeping registers; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            drop_cnt_q <= '0;
            err_sop_q  <= 1'b0;
`ifdef UNPACK_ARB_MAX_PKT_EN
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            drop_cnt_q <= drop_cnt_d;
            err_sop_q  <= err_sop_d;
`ifdef UNPACK_ARB_MAX_PKT_EN
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
`endif
        end
    end
endmodule
